hprb_source: RTL and testbench
==============================

Name: hprb_source

Overview:
- Probe message generator; sits directly upstream of the probe sink.
- Emits a stream of messages on one output channel using a 4-phase req/ack handshake. Each message carries src=MY_LOCAL_ADDR, dst=PRB_DST_ADDR, incrementing data and the calc_redun redundancy.
- Used in hlang channel tests: a source/sink pair exercises routing and handshake logic end-to-end.

Parameters:
- MY_LOCAL_ADDR, 0, address placed in every message src field.
- PRB_DST_ADDR, 0, address placed in every message dst field.
- ASZ, `NS_ADDRESS_SIZE, address field width.
- DSZ, `NS_DATA_SIZE, data field width.
- RSZ, `NS_REDUN_SIZE, redundancy field width.
- START_DAT, 0, data value of the first message after reset.
- NUM_MSGS, 0, messages to send before stopping; 0 = unlimited.
- SND_ACK_CKS, `NS_REQ_CKS, consecutive clocks ack must hold a level before it is accepted (debounce).

Ports:
- gch_clk  in  1  clock, all state on rising edge.
- gch_reset  in  1  asynchronous, active-high reset.
- gch_ready  out  1  block initialised and able to send.
- src_en  in  1  enable; a new message starts only while high.
- snd0_req_out  out  1  channel request.
- snd0_ack_in  in  1  channel acknowledge from the downstream sink.
- snd0_src  out  ASZ  message source address.
- snd0_dst  out  ASZ  message destination address.
- snd0_dat  out  DSZ  message data.
- snd0_red  out  RSZ  message redundancy.
- prb_done  out  1  NUM_MSGS messages completed (never set when NUM_MSGS=0).
- prb_count  out  16  completed message count, saturates at 16'hFFFF.

Behaviour:
- Reset (async) forces: gch_ready=0, snd0_req_out=0, snd0_src=0, snd0_dst=0, snd0_dat=0, snd0_red=0, prb_done=0, prb_count=0, state=INIT, ack debounce counter=0, ack_ckd=0.
- Ack debounce: ack_ckd takes the value of snd0_ack_in only after the input has held that level for SND_ACK_CKS consecutive clocks.
- FSM states:
  - INIT: first clock after reset release. Sets gch_ready=1, loads dat register with START_DAT, goes to IDLE.
  - IDLE: if src_en && !prb_done && !ack_ckd, drive src/dst/dat outputs and go to LOAD. Otherwise stay.
  - LOAD: register snd0_red from calc_redun(snd0_src, snd0_dst, snd0_dat); go to REQ. snd0_req_out is still 0.
  - REQ: snd0_req_out=1. When ack_ckd=1, drop req and go to WAIT.
  - WAIT: req=0. When ack_ckd=0:
    - increment prb_count;
    - advance dat by +1 modulo 2^DSZ (the MAX-to-0 wrap is legal for the sink);
    - set prb_done if NUM_MSGS!=0 and the count reaches NUM_MSGS;
    - go to IDLE.
- Minimum cycles per message: 2 (IDLE,LOAD) + 2*(SND_ACK_CKS+1) handshake cycles, plus sink latency.
- src/dst/dat/red are stable from req rise until ack_ckd falls. They change only in IDLE/LOAD.
- src_en deasserting mid-message has no effect: the current message completes, then the FSM holds in IDLE.
- Stale ack high in IDLE blocks a new request until ack_ckd=0.
- Reset asserted mid-handshake: req drops immediately (asynchronously). After release, the data sequence restarts at START_DAT.
- Once prb_done=1 it stays set until reset. The FSM stays in IDLE.
- gch_ready goes 0 only on reset.

Optional Feature:
- Macro HPRB_SOURCE_ERR_INJ_EN.
- When defined: adds input port inj_err (1 bit), sampled in LOAD. If it is 1, bit 0 of snd0_red is inverted for that message only. Everything else is unchanged.
- When undefined: no inj_err port and no injection logic; snd0_red is always the correct redundancy.

Test Plan:
- Reset, src_en=1, ideal sink acking after 2 clocks, NUM_MSGS=0 -> snd0_dat sequence 0,1,2,3,...; each message has src=MY_LOCAL_ADDR, dst=PRB_DST_ADDR, red=calc_redun; prb_count increments once per completed handshake.
- DSZ=4, START_DAT=14, NUM_MSGS=4 -> data 14,15,0,1; then prb_done=1, prb_count=4, no further req.
- Ack glitch shorter than SND_ACK_CKS during REQ -> req stays 1; a glitch-free ack of SND_ACK_CKS clocks is needed before req drops.
- Reset asserted while req=1 -> req=0 in the same cycle. After release, gch_ready=1 one clock later and the first message carries START_DAT.
- src_en dropped while in REQ -> current message completes, no new req; re-assert -> next data value continues without a gap.
- With HPRB_SOURCE_ERR_INJ_EN, inj_err=1 for message 3 -> only that message's red differs from calc_redun (bit 0 flipped); the downstream sink flags an error on that message.

Source files
------------

// File: rtl/hprb_source.sv
// ---------------------------------------------------------------------------
// hprb_source -- probe message generator
//
// Emits a stream of probe messages on one output channel using a 4-phase
// req/ack handshake. Every message carries src=MY_LOCAL_ADDR,
// dst=PRB_DST_ADDR, an incrementing data word and its redundancy code. It
// sits directly upstream of the probe sink in channel tests.
//
// Optional feature: define HPRB_SOURCE_ERR_INJ_EN to add the inj_err input.
// When inj_err is high while a message is loaded, bit 0 of that message's
// redundancy is inverted so the sink sees a corrupted message.
//
// Ports:
//   gch_clk       in   1    clock, all state on rising edge
//   gch_reset     in   1    asynchronous active-high reset
//   inj_err       in   1    (HPRB_SOURCE_ERR_INJ_EN only) corrupt this message
//   src_en        in   1    a new message starts only while high
//   gch_ready     out  1    block initialised and able to send
//   snd0_req_out  out  1    channel request
//   snd0_ack_in   in   1    channel acknowledge from the sink (debounced)
//   snd0_src      out  ASZ  message source address
//   snd0_dst      out  ASZ  message destination address
//   snd0_dat      out  DSZ  message data
//   snd0_red      out  RSZ  message redundancy
//   prb_done      out  1    NUM_MSGS messages completed (never when 0)
//   prb_count     out  16   completed messages, saturating
//
// Redundancy: calc_redun XOR-folds the concatenation {src, dst, dat}
// (zero-padded at the top to a multiple of RSZ) into RSZ-bit chunks,
// starting from the least-significant chunk.
// ---------------------------------------------------------------------------
`ifndef NS_ADDRESS_SIZE
`define NS_ADDRESS_SIZE 8
`endif
`ifndef NS_DATA_SIZE
`define NS_DATA_SIZE 16
`endif
`ifndef NS_REDUN_SIZE
`define NS_REDUN_SIZE 4
`endif
`ifndef NS_REQ_CKS
`define NS_REQ_CKS 2
`endif

module hprb_source #(
    parameter int unsigned MY_LOCAL_ADDR = 0,
    parameter int unsigned PRB_DST_ADDR  = 0,
    parameter int unsigned ASZ           = `NS_ADDRESS_SIZE,
    parameter int unsigned DSZ           = `NS_DATA_SIZE,
    parameter int unsigned RSZ           = `NS_REDUN_SIZE,
    parameter int unsigned START_DAT     = 0,
    parameter int unsigned NUM_MSGS      = 0,
    parameter int unsigned SND_ACK_CKS   = `NS_REQ_CKS
) (
    input  logic           gch_clk,
    input  logic           gch_reset,
`ifdef HPRB_SOURCE_ERR_INJ_EN
    input  logic           inj_err,
`endif
    input  logic           src_en,
    output logic           gch_ready,
    output logic           snd0_req_out,
    input  logic           snd0_ack_in,
    output logic [ASZ-1:0] snd0_src,
    output logic [ASZ-1:0] snd0_dst,
    output logic [DSZ-1:0] snd0_dat,
    output logic [RSZ-1:0] snd0_red,
    output logic           prb_done,
    output logic [15:0]    prb_count
);

    localparam int unsigned TW    = 2 * ASZ + DSZ;
    localparam int unsigned NCH   = (TW + RSZ - 1) / RSZ;
    localparam int unsigned PW    = NCH * RSZ;
    localparam int unsigned CNT_W = (SND_ACK_CKS < 2) ? 1 : $clog2(SND_ACK_CKS + 1);

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_LOAD,
        ST_REQ,
        ST_WAIT
    } state_t;

    function automatic logic [RSZ-1:0] calc_redun(input logic [ASZ-1:0] src,
                                                  input logic [ASZ-1:0] dst,
                                                  input logic [DSZ-1:0] dat);
        logic [PW-1:0]  w;
        logic [RSZ-1:0] r;
        w = PW'({src, dst, dat});
        r = '0;
        for (int c = 0; c < NCH; c++) begin
            r = r ^ w[c*RSZ +: RSZ];
        end
        return r;
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    state_t           r_state, w_state_nxt;
    logic             r_ready, w_ready_nxt;
    logic             r_req, w_req_nxt;
    logic [ASZ-1:0]   r_src, w_src_nxt;
    logic [ASZ-1:0]   r_dst, w_dst_nxt;
    logic [DSZ-1:0]   r_dat, w_dat_nxt;
    logic [RSZ-1:0]   r_red, w_red_nxt;
    logic [DSZ-1:0]   r_seq, w_seq_nxt;
    logic [15:0]      r_cnt, w_cnt_nxt;
    logic             r_done, w_done_nxt;
    logic [RSZ-1:0]   w_red_calc;
    logic [CNT_W-1:0] r_ack_cnt;
    logic             r_ack_ckd;

    // ---- ack debounce: accept a new level only after SND_ACK_CKS steady samples
    always_ff @(posedge gch_clk or posedge gch_reset) begin
        if (gch_reset) begin
            r_ack_cnt <= '0;
            r_ack_ckd <= 1'b0;
        end else if (snd0_ack_in == r_ack_ckd) begin
            r_ack_cnt <= '0;
        end else if (r_ack_cnt == CNT_W'(SND_ACK_CKS - 1)) begin
            r_ack_ckd <= snd0_ack_in;
            r_ack_cnt <= '0;
        end else begin
            r_ack_cnt <= r_ack_cnt + 1'b1;
        end
    end

    always_comb begin
`ifdef HPRB_SOURCE_ERR_INJ_EN
        w_red_calc = calc_redun(r_src, r_dst, r_dat) ^ RSZ'(inj_err);
`else
        w_red_calc = calc_redun(r_src, r_dst, r_dat);
`endif
    end

    // ---- message FSM: next state and next register values
    always_comb begin
        w_state_nxt = r_state;
        w_ready_nxt = r_ready;
        w_req_nxt   = r_req;
        w_src_nxt   = r_src;
        w_dst_nxt   = r_dst;
        w_dat_nxt   = r_dat;
        w_red_nxt   = r_red;
        w_seq_nxt   = r_seq;
        w_cnt_nxt   = r_cnt;
        w_done_nxt  = r_done;
        case (r_state)
            ST_INIT: begin
                w_ready_nxt = 1'b1;
                w_seq_nxt   = DSZ'(START_DAT);
                w_state_nxt = ST_IDLE;
            end
            ST_IDLE: begin
                // A stale ack still high from the previous message blocks a new request.
                if (src_en && !r_done && !r_ack_ckd) begin
                    w_src_nxt   = ASZ'(MY_LOCAL_ADDR);
                    w_dst_nxt   = ASZ'(PRB_DST_ADDR);
                    w_dat_nxt   = r_seq;
                    w_state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                w_red_nxt   = w_red_calc;
                w_req_nxt   = 1'b1;
                w_state_nxt = ST_REQ;
            end
            ST_REQ: begin
                if (r_ack_ckd) begin
                    w_req_nxt   = 1'b0;
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (!r_ack_ckd) begin
                    w_cnt_nxt = sat_inc(r_cnt);
                    // Data wraps MAX->0 naturally; the sink accepts the wrap.
                    w_seq_nxt = r_seq + 1'b1;
                    if ((NUM_MSGS != 0) && ({1'b0, r_cnt} + 17'd1 == 17'(NUM_MSGS))) begin
                        w_done_nxt = 1'b1;
                    end
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_INIT;
        endcase
    end

    // ---- state and output registers
    always_ff @(posedge gch_clk or posedge gch_reset) begin
        if (gch_reset) begin
            r_state <= ST_INIT;
            r_ready <= 1'b0;
            r_req   <= 1'b0;
            r_src   <= '0;
            r_dst   <= '0;
            r_dat   <= '0;
            r_red   <= '0;
            r_seq   <= '0;
            r_cnt   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ready <= w_ready_nxt;
            r_req   <= w_req_nxt;
            r_src   <= w_src_nxt;
            r_dst   <= w_dst_nxt;
            r_dat   <= w_dat_nxt;
            r_red   <= w_red_nxt;
            r_seq   <= w_seq_nxt;
            r_cnt   <= w_cnt_nxt;
            r_done  <= w_done_nxt;
        end
    end

    assign gch_ready    = r_ready;
    assign snd0_req_out = r_req;
    assign snd0_src     = r_src;
    assign snd0_dst     = r_dst;
    assign snd0_dat     = r_dat;
    assign snd0_red     = r_red;
    assign prb_done     = r_done;
    assign prb_count    = r_cnt;

endmodule

// File: tb/tb_hprb_source.sv
// ---------------------------------------------------------------------------
// tb_hprb_source -- directed bench for hprb_source.
// DUT: src=A6, dst=3C, DSZ=RSZ=4, START_DAT=14, NUM_MSGS=6, SND_ACK_CKS=3.
// Expected redundancy: nibbles of {A6,3C,d} fold to A^6^3^C^d = 3^d.
// ---------------------------------------------------------------------------
module tb_hprb_source;

    logic       clk = 1'b0;
    logic       rst;
    logic       src_en;
    logic       ack;
    logic       ready;
    logic       req;
    logic       done;
    logic [7:0] src;
    logic [7:0] dst;
    logic [3:0] dat;
    logic [3:0] red;
    logic [15:0] cnt;
`ifdef HPRB_SOURCE_ERR_INJ_EN
    logic       inj = 1'b0;
`endif

    int n_vec = 0;
    int n_mis = 0;

    always #5 clk = ~clk;

    hprb_source #(
        .MY_LOCAL_ADDR(32'hA6),
        .PRB_DST_ADDR (32'h3C),
        .ASZ          (8),
        .DSZ          (4),
        .RSZ          (4),
        .START_DAT    (14),
        .NUM_MSGS     (6),
        .SND_ACK_CKS  (3)
    ) dut (
        .gch_clk     (clk),
        .gch_reset   (rst),
`ifdef HPRB_SOURCE_ERR_INJ_EN
        .inj_err     (inj),
`endif
        .src_en      (src_en),
        .gch_ready   (ready),
        .snd0_req_out(req),
        .snd0_ack_in (ack),
        .snd0_src    (src),
        .snd0_dst    (dst),
        .snd0_dat    (dat),
        .snd0_red    (red),
        .prb_done    (done),
        .prb_count   (cnt)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h, want %0h", tag, act, exp);
        end
    endtask

    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 20 && !ok; n++) begin
            @(negedge clk);
            if (req) ok = 1'b1;
        end
    endtask

    // Plays the sink for one message: checks the payload, acks, checks debounce
    // latency on both edges and the completed count.
    task automatic send_msg(input logic [3:0] d, input int exp_cnt,
                            input bit glitch, input bit drop_en);
        bit ok;
        int n;
        wait_req(ok);
        chk("req_rise", 32'(ok), 1);
        chk("src", 32'(src), 'hA6);
        chk("dst", 32'(dst), 'h3C);
        chk("dat", 32'(dat), 32'(d));
        chk("red", 32'(red), 32'(4'h3 ^ d));
        if (drop_en) src_en = 1'b0;
        if (glitch) begin
            ack = 1'b1;
            @(negedge clk);
            @(negedge clk);
            ack = 1'b0;
            repeat (6) @(negedge clk);
            chk("glitch_req_held", 32'(req), 1);
        end
        ack = 1'b1;
        n = 0;
        while (req && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("ack_rise_lat", n, 4);
        chk("dat_hold", 32'(dat), 32'(d));
        chk("red_hold", 32'(red), 32'(4'h3 ^ d));
        ack = 1'b0;
        n = 0;
        while (32'(cnt) != exp_cnt && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("ack_fall_lat", n, 4);
        chk("count", 32'(cnt), exp_cnt);
    endtask

    initial begin
        bit ok;
        rst    = 1'b1;
        src_en = 1'b0;
        ack    = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(ready), 0);
        chk("rst_req",   32'(req),   0);
        chk("rst_src",   32'(src),   0);
        chk("rst_dst",   32'(dst),   0);
        chk("rst_dat",   32'(dat),   0);
        chk("rst_red",   32'(red),   0);
        chk("rst_done",  32'(done),  0);
        chk("rst_count", 32'(cnt),   0);

        rst = 1'b0;
        #1 chk("ready_before_init", 32'(ready), 0);
        @(negedge clk);
        chk("ready_after_init", 32'(ready), 1);
        repeat (3) @(negedge clk);
        chk("no_en_no_req", 32'(req), 0);

        src_en = 1'b1;
        send_msg(4'd14, 1, 1'b0, 1'b0);
        chk("done_early", 32'(done), 0);
        send_msg(4'd15, 2, 1'b1, 1'b0);
        send_msg(4'd0,  3, 1'b0, 1'b0);
        send_msg(4'd1,  4, 1'b0, 1'b1);
        repeat (6) @(negedge clk);
        chk("en_off_no_req", 32'(req), 0);
        chk("en_off_count",  32'(cnt), 4);
        src_en = 1'b1;
        send_msg(4'd2, 5, 1'b0, 1'b0);
        chk("done_at5", 32'(done), 0);
        send_msg(4'd3, 6, 1'b0, 1'b0);
        chk("done_at6", 32'(done), 1);
        repeat (10) @(negedge clk);
        chk("done_no_req",  32'(req),  0);
        chk("done_sticky",  32'(done), 1);
        chk("done_count",   32'(cnt),  6);
        chk("done_dat",     32'(dat),  3);
        chk("ready_stays",  32'(ready), 1);

        rst = 1'b1;
        @(negedge clk);
        chk("rst2_done",  32'(done), 0);
        chk("rst2_count", 32'(cnt),  0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst2_ready", 32'(ready), 1);
        wait_req(ok);
        chk("rst2_req_rise", 32'(ok), 1);
        chk("rst2_dat", 32'(dat), 14);
        #2 rst = 1'b1;
        #1 chk("async_req_drop", 32'(req), 0);
        chk("async_ready_drop", 32'(ready), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst3_ready", 32'(ready), 1);
        send_msg(4'd14, 1, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
